// File: rtl/post_tu_pkg.sv
// Shared types, transform coefficients and output helpers for the
// Winograd F(2x2,3x3) output-transform accumulator.
package post_tu_pkg;

  typedef enum logic {IDLE, ACC} state_t;

  localparam int AT [2][4] = '{
    '{1, 1,  1,  0},
    '{0, 1, -1, -1}
  };

  function automatic logic signed [63:0] round_shift(
    input logic signed [63:0] v,
    input int                 sh
  );
    logic signed [63:0] r;
    if (sh == 0) begin
      r = v;
    end else begin
      r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] v,
    input int                 ow
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/post_tu_acc_1d.sv
// 1D output transform: four W-bit values to two exact (W+2)-bit values.
import post_tu_pkg::*;

module post_tu_1d #(
  parameter int W = 28
) (
  input  logic signed [W-1:0] m [4],
  output logic signed [W+1:0] y [2]
);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      y[i] = '0;
      for (int k = 0; k < 4; k++) begin
        if (AT[i][k] == 1) begin
          y[i] = y[i] + (W+2)'(m[k]);
        end else if (AT[i][k] == -1) begin
          y[i] = y[i] - (W+2)'(m[k]);
        end
      end
    end
  end

endmodule

// File: rtl/post_tu_acc.sv
// Channel accumulator plus Y = A^T M A output transform, rounding,
// saturation and a registered valid/ready output tile.
import post_tu_pkg::*;

module post_tu_acc #(
  parameter int IW    = 20,
  parameter int AW    = 28,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [16*IW-1:0] in_tile,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*OW-1:0]  out_tile,
  output logic             busy
);

  localparam int TW = AW + 4;

  state_t state_q, state_d;

  logic signed [AW-1:0] acc_q [4][4];
  logic signed [AW-1:0] nxt   [4][4];
  logic signed [IW-1:0] elem  [4][4];
  logic signed [AW+1:0] t     [4][2];
  logic signed [AW+1:0] c0    [4];
  logic signed [AW+1:0] c1    [4];
  logic signed [TW-1:0] yc0   [2];
  logic signed [TW-1:0] yc1   [2];
  logic signed [TW-1:0] ysel  [4];
  logic signed [63:0]   v     [4];

  logic [4*OW-1:0] y_new;
  logic [4*OW-1:0] out_q;
  logic            ov_q;
  logic            fire;

  assign in_ready  = !ov_q || out_ready;
  assign fire      = in_valid && in_ready;
  assign out_valid = ov_q;
  assign out_tile  = out_q;
  assign busy      = (state_q == ACC);

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        elem[r][c] = in_tile[(4*r+c)*IW +: IW];
        nxt[r][c]  = (in_first ? '0 : acc_q[r][c])
                   + AW'(elem[r][c]);
      end
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_row
    post_tu_1d #(.W(AW)) u_row (
      .m (nxt[r]),
      .y (t[r])
    );
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      c0[r] = t[r][0];
      c1[r] = t[r][1];
    end
  end

  post_tu_1d #(.W(AW+2)) u_col0 (
    .m (c0),
    .y (yc0)
  );

  post_tu_1d #(.W(AW+2)) u_col1 (
    .m (c1),
    .y (yc1)
  );

  // Output order is (i,j) -> 2i+j.
  assign ysel[0] = yc0[0];
  assign ysel[1] = yc1[0];
  assign ysel[2] = yc0[1];
  assign ysel[3] = yc1[1];

  always_comb begin
    y_new = '0;
    for (int k = 0; k < 4; k++) begin
      v[k] = sat(round_shift(64'(ysel[k]), SHIFT), OW);
      y_new[k*OW +: OW] = v[k][OW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fire && !in_last) state_d = ACC;
      ACC:  if (fire && in_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      out_q   <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          acc_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (fire) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            acc_q[r][c] <= in_last ? '0 : nxt[r][c];
          end
        end
      end
      if (fire && in_last) begin
        out_q <= y_new;
        ov_q  <= 1'b1;
      end else if (out_ready) begin
        ov_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_post_tu_acc.sv
// Directed bench: two instances (SHIFT 0 and 1) share stimulus; a
// reference model feeds per-instance scoreboards of expected tiles.
module tb_post_tu_acc;

  localparam int IW = 20;
  localparam int AW = 28;
  localparam int OW = 16;

  localparam int BAT [2][4] = '{
    '{1, 1,  1,  0},
    '{0, 1, -1, -1}
  };

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_first;
  logic             in_last;
  logic [16*IW-1:0] in_tile;
  logic             out_ready;
  logic             in_ready0, in_ready1;
  logic             out_valid0, out_valid1;
  logic [4*OW-1:0]  out_tile0, out_tile1;
  logic             busy0, busy1;

  int errors = 0;
  int checks = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  longint      macc [16];
  int          ones [16];
  int          twos [16];
  int          big  [16];
  int          rnd  [16];

  always #5 clk = ~clk;

  post_tu_acc #(.IW(IW), .AW(AW), .OW(OW), .SHIFT(0)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_tile   (in_tile),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_tile  (out_tile0),
    .busy      (busy0)
  );

  post_tu_acc #(.IW(IW), .AW(AW), .OW(OW), .SHIFT(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_tile   (in_tile),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_tile  (out_tile1),
    .busy      (busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint x);
    return (x <<< (64 - AW)) >>> (64 - AW);
  endfunction

  function automatic logic [63:0] exp_tile(input longint m [16],
                                           input int sh);
    logic [63:0] res;
    longint      y;
    longint      hi;
    longint      lo;
    res = '0;
    hi  = (64'sd1 <<< (OW - 1)) - 1;
    lo  = -(64'sd1 <<< (OW - 1));
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        y = 0;
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            y += BAT[i][r] * m[4*r+c] * BAT[j][c];
          end
        end
        if (sh > 0) y = (y + (64'sd1 <<< (sh - 1))) >>> sh;
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        res[(2*i+j)*OW +: OW] = y[OW-1:0];
      end
    end
    return res;
  endfunction

  task automatic monitor();
    logic [63:0] e;
    if (out_valid0 && out_ready) begin
      if (q0.size() == 0) begin
        chk("unexpected_s0", 64'd1, 64'd0);
      end else begin
        e = q0.pop_front();
        chk("tile_s0", out_tile0, e);
      end
    end
    if (out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        chk("unexpected_s1", 64'd1, 64'd0);
      end else begin
        e = q1.pop_front();
        chk("tile_s1", out_tile1, e);
      end
    end
  endtask

  task automatic send(input bit f, input bit l, input int v [16]);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    for (int k = 0; k < 16; k++) in_tile[k*IW +: IW] = v[k][IW-1:0];
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      monitor();
      acc = in_ready0;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      macc[k] = wrap((f ? 64'sd0 : macc[k]) + longint'(v[k]));
    end
    if (l) begin
      q0.push_back(exp_tile(macc, 0));
      q1.push_back(exp_tile(macc, 1));
      for (int k = 0; k < 16; k++) macc[k] = 0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      ones[k] = 1;
      twos[k] = 2;
      big[k]  = 32767;
      macc[k] = 0;
    end
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_tile   = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_valid", 64'(out_valid0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_tile", 64'(out_tile0), 64'd0);
    chk("rst_ready", 64'(in_ready0), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-channel tile and one-cycle latency.
    send(1, 1, ones);
    chk("lat_valid", 64'(out_valid0), 64'd1);
    chk("single_s0", 64'(out_tile0), 64'h0001_FFFD_FFFD_0009);
    chk("single_s1", 64'(out_tile1), 64'h0001_FFFF_FFFF_0005);
    chk("single_busy", 64'(busy0), 64'd0);
    idle(2);
    chk("drained_valid", 64'(out_valid0), 64'd0);

    // Three channels with busy tracking.
    send(1, 0, ones);
    chk("busy_b0", 64'(busy0), 64'd1);
    send(0, 0, ones);
    chk("busy_b1", 64'(busy1), 64'd1);
    send(0, 1, ones);
    chk("busy_end", 64'(busy0), 64'd0);
    chk("three_s0", 64'(out_tile0), 64'h0003_FFF7_FFF7_001B);
    idle(2);
    send(0, 1, ones);
    idle(2);

    // Saturation.
    send(1, 1, big);
    idle(2);

    // Backpressure hold, then back-to-back with no bubble.
    out_ready = 1'b0;
    send(1, 1, ones);
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 16; k++) in_tile[k*IW +: IW] = twos[k][IW-1:0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 64'(in_ready0), 64'd0);
      chk("bp_valid", 64'(out_valid0), 64'd1);
      chk("bp_tile", 64'(out_tile0), q0[0]);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1, 1, twos);
    chk("b2b_valid", 64'(out_valid0), 64'd1);
    send(1, 1, big);
    chk("b2b_valid2", 64'(out_valid1), 64'd1);
    idle(3);

    // Restart mid-tile.
    send(1, 0, ones);
    send(0, 0, ones);
    send(1, 0, ones);
    send(0, 1, ones);
    chk("restart_s0", 64'(out_tile0), 64'h0002_FFFA_FFFA_0012);
    idle(2);

    // Reset mid-accumulation.
    send(1, 0, ones);
    send(0, 0, ones);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid0), 64'd0);
    chk("mrst_busy", 64'(busy0), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) macc[k] = 0;
    send(0, 1, ones);
    chk("post_rst", 64'(out_tile0), 64'h0001_FFFD_FFFD_0009);
    idle(2);

    // Random multi-channel tiles with occasional stalls.
    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 16; k++) begin
          rnd[k] = int'($urandom_range(0, 8000)) - 4000;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        send(b == 0, b == nb - 1, rnd);
      end
    end
    out_ready = 1'b1;
    idle(4);

    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
